// File: rtl/memory_pkg.sv
// Shared encodings and helpers for the data memory controller:
// access widths, controller states and lane helpers.
package memory_pkg;

  localparam logic [1:0] WIDTH_NONE = 2'd0;
  localparam logic [1:0] WIDTH_B    = 2'd1;
  localparam logic [1:0] WIDTH_H    = 2'd2;
  localparam logic [1:0] WIDTH_W    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Active byte lanes for an access; loads and stores use the same pattern.
  function automatic logic [3:0] byte_enable(input logic [1:0] width,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (width)
      WIDTH_B: be = 4'b0001 << addr_lo;
      WIDTH_H: be = 4'b0011 << addr_lo;
      WIDTH_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Copy LSB-justified store data onto every lane it could land on.
  function automatic logic [31:0] replicate_store(input logic [1:0] width,
                                                  input logic [31:0] data);
    logic [31:0] rep;
    case (width)
      WIDTH_B: rep = {4{data[7:0]}};
      WIDTH_H: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (width)
      WIDTH_H: bad = addr_lo[0];
      WIDTH_W: bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a bus word and sign- or
// zero-extends it; also usable by the writeback stage.
module load_extender
  import memory_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection followed by extension; an unsigned word is just the word.
  always_comb begin
    byte_lane = raw_data[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];
    ext_data  = '0;
    case (width)
      WIDTH_B: ext_data = is_unsigned ? {24'd0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      WIDTH_H: ext_data = is_unsigned ? {16'd0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      WIDTH_W: ext_data = raw_data;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding load/store controller between the execute-stage memory
// unit and the data bus: alignment check, lane formatting, req/ack handshake
// with timeout, and extended load data on a one-cycle response.
module data_memory_controller
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_width,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_write_data,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_read_data,
  output logic                  resp_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [3:0]            bus_byte_enable,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       cap_width;
  logic [1:0]       cap_addr_lo;
  logic             cap_unsigned;
  logic             cap_write;
  logic [31:0]      load_data;

  load_extender u_load_extender (
    .width       (cap_width),
    .addr_lo     (cap_addr_lo),
    .is_unsigned (cap_unsigned),
    .raw_data    (bus_read_data),
    .ext_data    (load_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign stall     = ~req_ready;

  // Request/handshake FSM; every bus and response output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      count           <= '0;
      cap_width       <= WIDTH_NONE;
      cap_addr_lo     <= 2'b00;
      cap_unsigned    <= 1'b0;
      cap_write       <= 1'b0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_address     <= '0;
      bus_byte_enable <= 4'b0000;
      bus_write_data  <= '0;
      resp_valid      <= 1'b0;
      resp_read_data  <= '0;
      resp_error      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_width    <= req_width;
            cap_addr_lo  <= req_address[1:0];
            cap_unsigned <= req_unsigned;
            cap_write    <= req_write;
            if (req_width == WIDTH_NONE || is_misaligned(req_width, req_address[1:0])) begin
              state          <= ST_RESP;
              resp_valid     <= 1'b1;
              resp_error     <= 1'b1;
              resp_read_data <= '0;
            end else begin
              state           <= ST_ISSUE;
              count           <= '0;
              bus_req         <= 1'b1;
              bus_we          <= req_write;
              bus_address     <= {req_address[ADDR_WIDTH-1:2], 2'b00};
              bus_byte_enable <= byte_enable(req_width, req_address[1:0]);
              bus_write_data  <= replicate_store(req_width, req_write_data);
            end
          end
        end
        ST_ISSUE: begin
          if (bus_ack) begin
            state          <= ST_RESP;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            resp_valid     <= 1'b1;
            resp_error     <= 1'b0;
            resp_read_data <= cap_write ? '0 : load_data;
          end else if (count == CNT_LAST) begin
            state          <= ST_RESP;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            resp_valid     <= 1'b1;
            resp_error     <= 1'b1;
            resp_read_data <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_RESP: begin
          state          <= ST_IDLE;
          resp_error     <= 1'b0;
          resp_read_data <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed plus randomized bench for data_memory_controller, checked against
// a lane-level reference model built from byte/half/word access rules.
module tb_data_memory_controller;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_ack = 1'b0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_memory_controller #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_width       (req_width),
    .req_unsigned    (req_unsigned),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_ready       (req_ready),
    .stall           (stall),
    .resp_valid      (resp_valid),
    .resp_read_data  (resp_read_data),
    .resp_error      (resp_error),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_address     (bus_address),
    .bus_byte_enable (bus_byte_enable),
    .bus_write_data  (bus_write_data),
    .bus_read_data   (bus_read_data),
    .bus_ack         (bus_ack)
  );

  // Number of bytes moved by an access; 0 marks the illegal width.
  function automatic int lane_count(input logic [1:0] w);
    case (w)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_error(input logic [1:0] w, input int a);
    int size;
    size = lane_count(w);
    return (size == 0) || ((a % size) != 0);
  endfunction

  // A lane is enabled when it falls inside [a, a+size).
  function automatic logic [3:0] model_be(input logic [1:0] w, input int a);
    logic [3:0] be;
    int size;
    size = lane_count(w);
    be = 4'b0000;
    for (int lane = 0; lane < 4; lane++)
      if (lane >= a && lane < a + size) be[lane] = 1'b1;
    return be;
  endfunction

  // Lane k carries store byte (k mod size).
  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    int size;
    size = lane_count(w);
    r = '0;
    for (int lane = 0; lane < 4; lane++)
      r[8*lane +: 8] = 8'((d >> (8 * (lane % size))) & 32'hFF);
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input int a,
                                             input logic uns, input logic [31:0] rd);
    longint val;
    longint span;
    int size;
    size = lane_count(w);
    if (size == 4) return rd;
    span = longint'(1) << (8 * size);
    val = (longint'(rd) >> (8 * a)) % span;
    if (!uns && val >= span / 2) val = val - span;
    return 32'(val);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // One full request; ack_delay<0 means the bus never acknowledges.
  task automatic applyStimulus(input logic wr, input logic [1:0] w, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int ack_delay);
    logic err;
    logic timed_out;
    int a;
    int cycles;
    int exp_cycles;
    a = int'(addr[1:0]);
    err = model_error(w, a);
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_width = w;
    req_unsigned = uns;
    req_address = addr;
    req_write_data = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (err) begin
      checkOutput("err_no_bus_req", 32'(bus_req), 32'd0);
      checkOutput("err_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("err_resp_error", 32'(resp_error), 32'd1);
      checkOutput("err_resp_data", resp_read_data, 32'd0);
    end else begin
      checkOutput("bus_req_rise", 32'(bus_req), 32'd1);
      checkOutput("stall_busy", 32'(stall), 32'd1);
      checkOutput("bus_we", 32'(bus_we), 32'(wr));
      checkOutput("bus_byte_enable", 32'(bus_byte_enable), 32'(model_be(w, a)));
      if (wr) checkOutput("bus_write_data", bus_write_data, model_wdata(w, wdata));
      cycles = 0;
      while (bus_req === 1'b1 && cycles < TIMEOUT + 4) begin
        checkOutput("bus_address", bus_address, {addr[31:2], 2'b00});
        req_valid = 1'b1;
        req_width = 2'd1;
        req_address = $urandom;
        req_unsigned = ~uns;
        if (cycles == ack_delay) begin
          bus_ack = 1'b1;
          bus_read_data = rdata;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_read_data = $urandom;
        cycles++;
      end
      req_valid = 1'b0;
      timed_out = !(ack_delay >= 0 && ack_delay < TIMEOUT);
      exp_cycles = timed_out ? TIMEOUT : ack_delay + 1;
      checkOutput("bus_req_cycles", 32'(cycles), 32'(exp_cycles));
      checkOutput("resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("resp_error", 32'(resp_error), 32'(timed_out));
      checkOutput("resp_read_data", resp_read_data,
                  (wr || timed_out) ? 32'd0 : model_load(w, a, uns, rdata));
    end
    @(negedge clk);
    checkOutput("resp_pulse_end", 32'(resp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    checkOutput("bus_req_idle", 32'(bus_req), 32'd0);
  endtask

  initial begin
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_address", bus_address, 32'd0);
    checkOutput("rst_bus_be", 32'(bus_byte_enable), 32'd0);
    checkOutput("rst_bus_wdata", bus_write_data, 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_read_data, 32'd0);
    checkOutput("rst_resp_error", 32'(resp_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed transactions");
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h203, 32'h000000A5, 32'h0, 0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 32'h12348056, 0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h301, 32'h0, 32'h12348056, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h402, 32'h0, 32'hF00D1234, 1);
    applyStimulus(1'b0, 2'd2, 1'b1, 32'h402, 32'h0, 32'hF00D1234, 1);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h502, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h600, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h700, 32'h0, 32'h0, -1);
    applyStimulus(1'b0, 2'd3, 1'b1, 32'h704, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h802, 32'h0000BEEF, 32'h0, 0);

    $display("[TB] stray ack in idle");
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    checkOutput("stray_bus_req", 32'(bus_req), 32'd0);
    checkOutput("stray_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("stray_req_ready", 32'(req_ready), 32'd1);

    $display("[TB] reset during issue");
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_width = 2'd3;
    req_address = 32'h900;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mid_bus_req_high", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("post_rst_no_bus", 32'(bus_req), 32'd0);
    end

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      int dly;
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                    $urandom, $urandom, dly);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
